booth_mult_seq: RTL and testbench

- Iterative radix-2 Booth multiplier. Parametrised successor to the team's 4-bit combinational Booth multiplier.
- Generalised to WIDTH-bit operands, with a per-operation signed/unsigned mode.
- Processes one Booth step per clock and uses a start/busy/done handshake.
- Sits beside datapath blocks that need an area-cheap multiply and can tolerate WIDTH+1 cycles of latency.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_step.sv | 35 +++
 rtl/booth_mult_seq.sv | 114 +++++++++++
 tb/tb_booth_mult_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Booth pair {Qr[0], q_1}; 2'b11 is also a no-op.
    localparam logic [1:0] BOOTH_NOP = 2'b00;
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Step counter must hold 0..WIDTH+1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth step: conditional add/sub of Mr, then
// arithmetic right shift of {A, Qr, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int E = 9
) (
    input  logic [E-1:0] i_a,
    input  logic [E-1:0] i_qr,
    input  logic         i_q1,
    input  logic [E-1:0] i_mr,
    output logic [E-1:0] o_a,
    output logic [E-1:0] o_qr,
    output logic         o_q1
);

    logic [1:0]   w_pair;
    logic [E-1:0] w_sum;

    assign w_pair = {i_qr[0], i_q1};

    always_comb begin
        w_sum = i_a;
        case (w_pair)
            BOOTH_ADD: w_sum = i_a + i_mr;
            BOOTH_SUB: w_sum = i_a - i_mr;
            default:   w_sum = i_a;
        endcase
    end

    assign o_a  = {w_sum[E-1], w_sum[E-1:1]};
    assign o_qr = {w_sum[0], i_qr[E-1:1]};
    assign o_q1 = i_qr[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-2 Booth multiplier, one step per clock, WIDTH+1-bit signed
// datapath so signed and unsigned operands share the same arithmetic.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_tc,
    input  logic [WIDTH-1:0]   i_multiplicand,
    input  logic [WIDTH-1:0]   i_multiplier,
    output logic               o_busy,
    output logic               o_done,
    output logic [2*WIDTH-1:0] o_product
);

    localparam int E  = WIDTH + 1;
    localparam int CW = cnt_width(WIDTH);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [E-1:0]         r_a;
    logic [E-1:0]         r_qr;
    logic [E-1:0]         r_mr;
    logic                 r_q1;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [E-1:0]         w_a_nxt;
    logic [E-1:0]         w_qr_nxt;
    logic                 w_q1_nxt;
    logic [E-1:0]         w_m_ext;
    logic [E-1:0]         w_q_ext;
    logic                 w_last_step;

    // Zero-extension for unsigned keeps the top bit clear, so the signed
    // Booth recoding produces the unsigned product.
    assign w_m_ext     = i_tc ? {i_multiplicand[WIDTH-1], i_multiplicand} : {1'b0, i_multiplicand};
    assign w_q_ext     = i_tc ? {i_multiplier[WIDTH-1], i_multiplier}     : {1'b0, i_multiplier};
    assign w_last_step = (r_cnt == CW'(E - 1));

    booth_step #(.E(E)) u_step (
        .i_a  (r_a),
        .i_qr (r_qr),
        .i_q1 (r_q1),
        .i_mr (r_mr),
        .o_a  (w_a_nxt),
        .o_qr (w_qr_nxt),
        .o_q1 (w_q1_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = CALC;
            end
            CALC: begin
                o_busy = 1'b1;
                if (w_last_step) w_state_nxt = DONE;
            end
            DONE: begin
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a       <= '0;
            r_qr      <= '0;
            r_mr      <= '0;
            r_q1      <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_mr  <= w_m_ext;
                        r_qr  <= w_q_ext;
                        r_a   <= '0;
                        r_q1  <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                CALC: begin
                    r_a   <= w_a_nxt;
                    r_qr  <= w_qr_nxt;
                    r_q1  <= w_q1_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    // The true product fits in 2*WIDTH bits in both modes.
                    if (w_last_step) r_product <= {w_a_nxt[E-3:0], w_qr_nxt};
                end
                default: ;
            endcase
        end
    end

    assign o_product = r_product;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Scoreboard bench for booth_mult_seq: WIDTH=4 directed corners, WIDTH=8 random and back-to-back.
module tb_booth_mult_seq;

    localparam int E4 = 5;
    localparam int E8 = 9;

    typedef struct {
        logic [15:0] prod;
        int          k;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start4 = 1'b0, tc4 = 1'b0;
    logic [3:0]  m4 = '0, q4v = '0;
    logic        busy4, done4;
    logic [7:0]  prod4;
    logic        start8 = 1'b0, tc8 = 1'b0;
    logic [7:0]  m8 = '0, q8v = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    sb_t sbq4[$];
    sb_t sbq8[$];

    booth_mult_seq #(.WIDTH(4)) u4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_tc(tc4),
        .i_multiplicand(m4), .i_multiplier(q4v),
        .o_busy(busy4), .o_done(done4), .o_product(prod4)
    );

    booth_mult_seq #(.WIDTH(8)) u8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_tc(tc8),
        .i_multiplicand(m8), .i_multiplier(q8v),
        .o_busy(busy8), .o_done(done8), .o_product(prod8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference product from plain integer arithmetic on the interpreted operands.
    function automatic logic [63:0] ref_prod(input int w, input bit tc, input logic [31:0] m, input logic [31:0] q);
        longint a, b, p;
        logic [63:0] mask;
        a = longint'(m);
        b = longint'(q);
        if (tc && m[w-1]) a = a - (longint'(1) << w);
        if (tc && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: done pops the scoreboard; latency is E edges from the start
    // edge (E+2 counting request edge and sampling edge inclusively).
    logic [7:0]  last4 = '0;
    logic [15:0] last8 = '0;
    logic        pdone4 = 1'b0, pdone8 = 1'b0;

    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            last4 = '0;
            pdone4 = 1'b0;
        end else if (done4) begin
            chk("w4_done_one_cycle", pdone4, 1'b0);
            if (sbq4.size() == 0) begin
                chk("w4_spurious_done", 1'b1, 1'b0);
            end else begin
                e = sbq4.pop_front();
                chk("w4_product", prod4, e.prod[7:0]);
                chk("w4_latency", cyc - e.k, E4);
            end
            last4 = prod4;
            pdone4 = 1'b1;
        end else begin
            chk("w4_product_stable", prod4, last4);
            pdone4 = 1'b0;
        end
    end

    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            last8 = '0;
            pdone8 = 1'b0;
        end else if (done8) begin
            chk("w8_done_one_cycle", pdone8, 1'b0);
            if (sbq8.size() == 0) begin
                chk("w8_spurious_done", 1'b1, 1'b0);
            end else begin
                e = sbq8.pop_front();
                chk("w8_product", prod8, e.prod);
                chk("w8_latency", cyc - e.k, E8);
            end
            last8 = prod8;
            pdone8 = 1'b1;
        end else begin
            chk("w8_product_stable", prod8, last8);
            pdone8 = 1'b0;
        end
    end

    task automatic wait_idle4();
        for (int n = 0; n < 64 && busy4 === 1'b1; n++) tick();
        chk("w4_idle_wait", busy4, 1'b0);
    endtask

    // With toggle set, start and operands are scrambled while busy; they must be ignored.
    task automatic wait_idle8(input bit toggle);
        for (int n = 0; n < 64 && busy8 === 1'b1; n++) begin
            if (toggle) begin
                start8 = 1'($urandom_range(0, 1));
                tc8    = 1'($urandom_range(0, 1));
                m8     = 8'($urandom);
                q8v    = 8'($urandom);
            end
            tick();
        end
        if (toggle) start8 = 1'b0;
        chk("w8_idle_wait", busy8, 1'b0);
    endtask

    task automatic issue4(input bit tc, input logic [3:0] m, input logic [3:0] q, input logic [7:0] exp);
        sb_t e;
        wait_idle4();
        start4 = 1'b1; tc4 = tc; m4 = m; q4v = q;
        e.prod = {8'h00, exp};
        e.k    = cyc + 1;
        sbq4.push_back(e);
        tick();
        start4 = 1'b0;
    endtask

    task automatic issue8(input bit tc, input logic [7:0] m, input logic [7:0] q);
        sb_t e;
        logic [63:0] r;
        wait_idle8(1'b1);
        start8 = 1'b1; tc8 = tc; m8 = m; q8v = q;
        r = ref_prod(8, tc, {24'h0, m}, {24'h0, q});
        e.prod = r[15:0];
        e.k    = cyc + 1;
        sbq8.push_back(e);
        tick();
        start8 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_k;
        sb_t e;
        logic [63:0] r;

        tick(); tick();
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_prod4", prod4, 8'h00);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_done8", done8, 1'b0);
        chk("rst_prod8", prod8, 16'h0000);
        rst_n = 1'b1;
        tick();

        // 3*2 with busy held through CALC and DONE, low again afterwards.
        issue4(1'b1, 4'd3, 4'd2, 8'h06);
        for (int i = 0; i <= E4; i++) begin
            chk("w4_busy_during_op", busy4, 1'b1);
            tick();
        end
        chk("w4_busy_after_op", busy4, 1'b0);

        issue4(1'b1, 4'hD, 4'h2, 8'hFA);
        issue4(1'b1, 4'h3, 4'hE, 8'hFA);
        issue4(1'b1, 4'h0, 4'h2, 8'h00);
        issue4(1'b1, 4'h8, 4'h8, 8'h40);
        issue4(1'b0, 4'hF, 4'hF, 8'hE1);
        issue4(1'b1, 4'h8, 4'h7, 8'hC8);
        wait_idle4();

        issue8(1'b1, 8'h80, 8'h80);
        issue8(1'b0, 8'hFF, 8'hFF);
        issue8(1'b1, 8'h00, 8'h7F);
        for (int mode = 0; mode < 2; mode++)
            for (int i = 0; i < 500; i++)
                issue8(mode[0], 8'($urandom), 8'($urandom));
        wait_idle8(1'b1);

        // start held high: a new operation every E+2 cycles.
        start8 = 1'b1;
        prev_k = 0;
        for (int i = 0; i < 5; i++) begin
            wait_idle8(1'b0);
            tc8 = 1'($urandom_range(0, 1)); m8 = 8'($urandom); q8v = 8'($urandom);
            r = ref_prod(8, tc8, {24'h0, m8}, {24'h0, q8v});
            e.prod = r[15:0];
            e.k    = cyc + 1;
            sbq8.push_back(e);
            if (i > 0) chk("hold_period", e.k - prev_k, E8 + 2);
            prev_k = e.k;
            tick();
        end
        start8 = 1'b0;
        wait_idle8(1'b0);

        // Reset in the third CALC cycle aborts the operation silently.
        issue8(1'b1, 8'h5A, 8'hC3);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy8", busy8, 1'b0);
        chk("midrst_done8", done8, 1'b0);
        chk("midrst_prod8", prod8, 16'h0000);
        sbq8.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        issue8(1'b1, 8'hF9, 8'h0D);
        wait_idle8(1'b0);
        wait_idle4();
        tick(); tick(); tick();

        chk("w4_scoreboard_empty", sbq4.size(), 0);
        chk("w8_scoreboard_empty", sbq8.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
